// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port integer register file with a per-register busy
// scoreboard, write-to-read bypass, hardwired-zero entry 0 and a sequential
// clear engine that zeroes the array one entry per cycle without a reset.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-low reset
//   rd_wr_i/addr/data    writeback port
//   rs_addr_i            NR packed read addresses (port k at [k*address +: address])
//   rs_data_o            NR packed read data (port k at [k*n +: n])
//   rs_busy_o            per-port unresolved-operand flag
//   iss_vld_i/iss_addr_i issue request claiming a destination register
//   stall_o              issue must be held this cycle
//   clr_i                start clearing the array
//   clr_busy_o           clear engine active
//   clr_done_o           high during the cycle that writes the last entry
module regfile_sb #(
  parameter int unsigned n       = 32,
  parameter int unsigned address = 5,
  parameter int unsigned m       = 32,
  parameter int unsigned NR      = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rd_wr_i,
  input  logic [address-1:0]      rd_addr_i,
  input  logic [n-1:0]            rd_data_i,
  input  logic [NR*address-1:0]   rs_addr_i,
  output logic [NR*n-1:0]         rs_data_o,
  output logic [NR-1:0]           rs_busy_o,
  input  logic                    iss_vld_i,
  input  logic [address-1:0]      iss_addr_i,
  output logic                    stall_o,
  input  logic                    clr_i,
  output logic                    clr_busy_o,
  output logic                    clr_done_o
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [address-1:0] LastAddr = address'(m - 1);

  state_e             state_q, state_d;
  logic [address-1:0] cnt_q, cnt_d;
  logic [n-1:0]       mem_q [m];
  logic [m-1:0]       busy_q;

  logic clearing;
  logic clr_start;
  logic wr_en;
  logic iss_ok;
  logic waw;

  assign clearing  = (state_q == StClear);
  assign clr_start = !clearing && clr_i;
  assign wr_en     = !clearing && rd_wr_i && (rd_addr_i != '0);
  assign iss_ok    = !clearing && iss_vld_i && !stall_o && (iss_addr_i != '0);

  // Read ports: entry 0 is hardwired zero; bypass only outside CLEAR.
  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [address-1:0] a;
    logic               hit;
    assign a   = rs_addr_i[k*address +: address];
    assign hit = rd_wr_i && (rd_addr_i == a);
    assign rs_data_o[k*n +: n] = (a == '0)          ? '0        :
                                 (hit && !clearing) ? rd_data_i : mem_q[a];
    assign rs_busy_o[k] = busy_q[a] && !hit && (a != '0) && !clearing;
  end

  // A writeback landing on the issue target this cycle resolves the WAW hazard.
  assign waw = iss_vld_i && (iss_addr_i != '0) && busy_q[iss_addr_i] &&
               !(rd_wr_i && (rd_addr_i == iss_addr_i));

  assign stall_o    = clearing || (|rs_busy_o) || waw;
  assign clr_busy_o = clearing;
  assign clr_done_o = clearing && (cnt_q == LastAddr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_i) begin
          state_d = StClear;
          cnt_d   = address'(1);
        end
      end
      StClear: begin
        cnt_d = cnt_q + address'(1);
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < m; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clearing) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[rd_addr_i] <= rd_data_i;
    end
  end

  // Issue set is ordered after the writeback clear so the set wins on a tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= '0;
    end else if (clr_start) begin
      busy_q <= '0;
    end else if (!clearing) begin
      if (wr_en) begin
        busy_q[rd_addr_i] <= 1'b0;
      end
      if (iss_ok) begin
        busy_q[iss_addr_i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a vector table replayed through a
// scoreboard queue, then hand-written clear and reset-mid-clear sequences.
module tb_regfile_sb;

  localparam int N  = 32;
  localparam int A  = 5;
  localparam int M  = 32;
  localparam int NR = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              rd_wr_i;
  logic [A-1:0]      rd_addr_i;
  logic [N-1:0]      rd_data_i;
  logic [A-1:0]      rs0, rs1;
  logic [NR*A-1:0]   rs_addr_i;
  logic [NR*N-1:0]   rs_data_o;
  logic [NR-1:0]     rs_busy_o;
  logic              iss_vld_i;
  logic [A-1:0]      iss_addr_i;
  logic              stall_o;
  logic              clr_i;
  logic              clr_busy_o;
  logic              clr_done_o;

  assign rs_addr_i = {rs1, rs0};

  regfile_sb #(.n(N), .address(A), .m(M), .NR(NR)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_wr_i    (rd_wr_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_i  (rd_data_i),
    .rs_addr_i  (rs_addr_i),
    .rs_data_o  (rs_data_o),
    .rs_busy_o  (rs_busy_o),
    .iss_vld_i  (iss_vld_i),
    .iss_addr_i (iss_addr_i),
    .stall_o    (stall_o),
    .clr_i      (clr_i),
    .clr_busy_o (clr_busy_o),
    .clr_done_o (clr_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         rd_wr;
    logic [A-1:0] rd_addr;
    logic [N-1:0] rd_data;
    logic [A-1:0] rs0;
    logic [A-1:0] rs1;
    logic         iss_vld;
    logic [A-1:0] iss_addr;
    logic [N-1:0] d0;
    logic [N-1:0] d1;
    logic [1:0]   busy;
    logic         stall;
  } vec_t;

  typedef struct {
    int           idx;
    logic [N-1:0] d0;
    logic [N-1:0] d1;
    logic [1:0]   busy;
    logic         stall;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] model [M];

  function automatic vec_t mk(logic wr, logic [A-1:0] wa, logic [N-1:0] wd,
                              logic [A-1:0] r0, logic [A-1:0] r1,
                              logic iv, logic [A-1:0] ia,
                              logic [N-1:0] d0, logic [N-1:0] d1,
                              logic [1:0] busy, logic stall);
    vec_t v;
    v.rd_wr = wr; v.rd_addr = wa; v.rd_data = wd; v.rs0 = r0; v.rs1 = r1;
    v.iss_vld = iv; v.iss_addr = ia; v.d0 = d0; v.d1 = d1; v.busy = busy; v.stall = stall;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_wr_i = 1'b0; rd_addr_i = '0; rd_data_i = '0;
    rs0 = '0; rs1 = '0; iss_vld_i = 1'b0; iss_addr_i = '0; clr_i = 1'b0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk_i);
    rd_wr_i = v.rd_wr; rd_addr_i = v.rd_addr; rd_data_i = v.rd_data;
    rs0 = v.rs0; rs1 = v.rs1; iss_vld_i = v.iss_vld; iss_addr_i = v.iss_addr;
    e.idx = idx; e.d0 = v.d0; e.d1 = v.d1; e.busy = v.busy; e.stall = v.stall;
    sb_q.push_back(e);
    #2;
    got = sb_q.pop_front();
    check($sformatf("vec%0d d0", got.idx), 64'(rs_data_o[N-1:0]), 64'(got.d0));
    check($sformatf("vec%0d d1", got.idx), 64'(rs_data_o[2*N-1:N]), 64'(got.d1));
    check($sformatf("vec%0d busy", got.idx), 64'(rs_busy_o), 64'(got.busy));
    check($sformatf("vec%0d stall", got.idx), 64'(stall_o), 64'(got.stall));
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;
    bit ended;

    idle_inputs();
    rst_i = 1'b0;
    #2;
    check("reset clr_busy", 64'(clr_busy_o), 64'd0);
    check("reset clr_done", 64'(clr_done_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // x0, bypass, RAW, WAW, issue/writeback tie, stall blocking issue
    vecs.push_back(mk(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
    vecs.push_back(mk(1, 5, 32'h12345678, 5, 6, 0, 0, 32'h12345678, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 5, 0, 0, 0, 32'h12345678, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, 0, 2'b10, 1));
    vecs.push_back(mk(1, 7, 32'hA5, 0, 7, 0, 0, 0, 32'hA5, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 7, 0, 0, 0, 32'hA5, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 9, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 9, 0, 0, 2'b00, 1));
    vecs.push_back(mk(1, 9, 32'h99, 0, 0, 1, 9, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 9, 0, 0, 0, 32'h99, 0, 2'b01, 1));
    vecs.push_back(mk(1, 9, 32'h100, 9, 0, 0, 0, 32'h100, 0, 2'b00, 0));
    vecs.push_back(mk(1, 3, 32'h33, 0, 0, 1, 3, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 3, 5, 0, 0, 32'h33, 32'h12345678, 2'b01, 1));
    vecs.push_back(mk(1, 3, 32'h34, 3, 9, 0, 0, 32'h34, 32'h100, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 10, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 10, 0, 1, 11, 0, 0, 2'b01, 1));
    vecs.push_back(mk(0, 0, 0, 0, 11, 0, 0, 0, 0, 2'b00, 0));

    foreach (vecs[i]) apply(i, vecs[i]);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    // Clear: load every entry, mark x4 busy, then pulse clr_i.
    for (int i = 1; i < M; i++) begin
      @(negedge clk_i);
      idle_inputs();
      rd_wr_i = 1'b1; rd_addr_i = A'(i); rd_data_i = 32'hA000_0000 + N'(i);
      model[i] = 32'hA000_0000 + N'(i);
    end
    @(negedge clk_i);
    idle_inputs();
    iss_vld_i = 1'b1; iss_addr_i = 5'd4;
    @(negedge clk_i);
    idle_inputs();
    rs0 = 5'd4;
    #2;
    check("x4 busy before clear", 64'(rs_busy_o[0]), 64'd1);
    @(negedge clk_i);
    clr_i = 1'b1; rs0 = 5'd2;
    #2;
    check("clr_busy before edge", 64'(clr_busy_o), 64'd0);
    check("x2 loaded", 64'(rs_data_o[N-1:0]), 64'(model[2]));

    busy_cnt = 0; done_cnt = 0; done_at = 0; ended = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      rd_wr_i = 1'b1; rd_addr_i = 5'd2; rd_data_i = 32'hFFFF_FFFF;
      iss_vld_i = 1'b1; iss_addr_i = 5'd6; rs0 = 5'd2; rs1 = 5'd4;
      if (c >= 5) clr_i = 1'b0;
      #2;
      if (c == 0) begin
        check("clear no bypass", 64'(rs_data_o[N-1:0]), 64'(model[2]));
        check("clear old x4", 64'(rs_data_o[2*N-1:N]), 64'(model[4]));
        check("clear rs_busy", 64'(rs_busy_o), 64'd0);
        check("clear stall", 64'(stall_o), 64'd1);
      end
      if (clr_done_o) begin
        done_cnt++;
        done_at = busy_cnt + 1;
      end
      if (clr_busy_o) begin
        busy_cnt++;
      end else begin
        idle_inputs();
        ended = 1'b1;
        break;
      end
    end
    check("clear ended in time", 64'(ended), 64'd1);
    check("clr_busy cycles", 64'(busy_cnt), 64'(M - 1));
    check("clr_done pulses", 64'(done_cnt), 64'd1);
    check("clr_done position", 64'(done_at), 64'(M - 1));

    for (int i = 1; i < M; i += 2) begin
      @(negedge clk_i);
      idle_inputs();
      rs0 = A'(i); rs1 = A'(i + 1);
      #2;
      check($sformatf("cleared x%0d", i), 64'(rs_data_o[N-1:0]), 64'd0);
      check($sformatf("cleared x%0d", (i + 1) % M), 64'(rs_data_o[2*N-1:N]), 64'd0);
      check($sformatf("cleared busy %0d", i), 64'(rs_busy_o), 64'd0);
      check($sformatf("cleared stall %0d", i), 64'(stall_o), 64'd0);
    end

    // Reset asserted on the tenth CLEAR cycle.
    @(negedge clk_i);
    idle_inputs();
    rd_wr_i = 1'b1; rd_addr_i = 5'd31; rd_data_i = 32'h77;
    @(negedge clk_i);
    idle_inputs();
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    repeat (9) @(negedge clk_i);
    rs0 = 5'd31;
    #2;
    check("mid-clear busy", 64'(clr_busy_o), 64'd1);
    check("mid-clear x31 intact", 64'(rs_data_o[N-1:0]), 64'h77);
    rst_i = 1'b0;
    #1;
    check("abort clr_busy", 64'(clr_busy_o), 64'd0);
    check("abort clr_done", 64'(clr_done_o), 64'd0);
    check("abort x31", 64'(rs_data_o[N-1:0]), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rd_wr_i = 1'b1; rd_addr_i = 5'd5; rd_data_i = 32'h55;
    #2;
    check("idle after release", 64'(clr_busy_o), 64'd0);
    @(negedge clk_i);
    idle_inputs();
    rs0 = 5'd5;
    #2;
    check("write after release", 64'(rs_data_o[N-1:0]), 64'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
